// File: rtl/mcp3008_pkg.sv
// Shared types and constants for the MCP3008 SPI responder.
// Also holds the pseudo-differential subtract-and-clamp helper.
package mcp3008_pkg;

    localparam int ADC_BITS = 10;
    localparam int NUM_CH   = 8;
    localparam int CMD_BITS = 4;
    localparam int BITCNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        CMD,
        SAMPLE,
        NULL,
        DATA,
        TRAIL
    } state_t;

    typedef logic [ADC_BITS-1:0] sample_t;

    // Pseudo-differential result: a - b as 11-bit signed, negative clamps to zero.
    function automatic sample_t clamp_diff(input sample_t a, input sample_t b);
        logic [ADC_BITS:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[ADC_BITS] ? '0 : diff[ADC_BITS-1:0];
    endfunction

endpackage

// File: rtl/mcp3008_responder_sig_sync_edge.sv
// Multi-stage synchronizer for one asynchronous input, plus an edge-detect
// flop that yields single-clk rise/fall pulses of the synchronized level.
module sig_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbour and the chain shifts by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/mcp3008_responder.sv
// MCP3008-compatible SPI responder: decodes start/SGL/D2..D0 from the master
// and shifts back a null bit plus the selected 10-bit sample, MSB first.
module mcp3008_responder
    import mcp3008_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sclk,
    input  logic                         cs_n,
    input  logic                         din,
    output logic                         dout,
    output logic                         dout_oe,
    input  logic [NUM_CH*ADC_BITS-1:0]   ch_data,
    output logic                         conv_valid,
    output logic                         conv_sgl,
    output logic [2:0]                   conv_channel,
    output logic                         frame_err
);

    localparam logic [BITCNT_W-1:0] CMD_LAST = BITCNT_W'(CMD_BITS - 1);
    localparam logic [BITCNT_W-1:0] DATA_MSB = BITCNT_W'(ADC_BITS - 1);

    logic sclk_rise, sclk_fall;
    logic cs_high;
    logic din_lvl;

    sig_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk   (clk),
        .rst   (rst),
        .d     (sclk),
        .level (),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    sig_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk   (clk),
        .rst   (rst),
        .d     (cs_n),
        .level (cs_high),
        .rise  (),
        .fall  ()
    );

    sig_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_din (
        .clk   (clk),
        .rst   (rst),
        .d     (din),
        .level (din_lvl),
        .rise  (),
        .fall  ()
    );

    state_t                state_q, state_d;
    logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [CMD_BITS-1:0]   cmd_q, cmd_d;
    sample_t               result_q, result_d;
    logic                  dout_q, dout_d;
    logic                  dout_oe_q, dout_oe_d;
    logic                  conv_valid_q, conv_valid_d;
    logic                  conv_sgl_q, conv_sgl_d;
    logic [2:0]            conv_channel_q, conv_channel_d;
    logic                  frame_err_q, frame_err_d;
    logic                  armed_q, armed_d;
    logic                  seen_r_q, seen_r_d;

    sample_t ch [NUM_CH];
    sample_t sample_value;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch[i] = ch_data[i*ADC_BITS +: ADC_BITS];
        end
    end

    // cmd_q = {SGL, D2, D1, D0}; differential pairs are {D2,D1} with D0 picking polarity.
    always_comb begin
        if (cmd_q[3]) begin
            sample_value = ch[cmd_q[2:0]];
        end else if (cmd_q[0]) begin
            sample_value = clamp_diff(ch[{cmd_q[2:1], 1'b1}], ch[{cmd_q[2:1], 1'b0}]);
        end else begin
            sample_value = clamp_diff(ch[{cmd_q[2:1], 1'b0}], ch[{cmd_q[2:1], 1'b1}]);
        end
    end

    // NOTE: every signal assigned below gets its hold/default value first, so no
    // branch can leave one unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        bitcnt_d       = bitcnt_q;
        cmd_d          = cmd_q;
        result_d       = result_q;
        dout_d         = dout_q;
        dout_oe_d      = dout_oe_q;
        conv_valid_d   = 1'b0;
        conv_sgl_d     = conv_sgl_q;
        conv_channel_d = conv_channel_q;
        frame_err_d    = 1'b0;
        armed_d        = armed_q;
        seen_r_d       = seen_r_q;

        if (cs_high) begin
            // Chip select wins over any simultaneous sclk edge.
            state_d     = IDLE;
            dout_d      = 1'b0;
            dout_oe_d   = 1'b0;
            armed_d     = 1'b1;
            frame_err_d = (state_q == WAIT_START && seen_r_q) ||
                          (state_q inside {CMD, SAMPLE, NULL, DATA});
        end else begin
            unique case (state_q)
                IDLE: begin
                    seen_r_d = 1'b0;
                    if (armed_q) state_d = WAIT_START;
                end
                WAIT_START: begin
                    if (sclk_rise) begin
                        seen_r_d = 1'b1;
                        if (din_lvl) begin
                            state_d  = CMD;
                            bitcnt_d = '0;
                        end
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        cmd_d = {cmd_q[CMD_BITS-2:0], din_lvl};
                        if (bitcnt_q == CMD_LAST) begin
                            state_d = SAMPLE;
                        end else begin
                            bitcnt_d = bitcnt_q + 1'b1;
                        end
                    end
                end
                SAMPLE: begin
                    if (sclk_rise) begin
                        result_d       = sample_value;
                        conv_valid_d   = 1'b1;
                        conv_sgl_d     = cmd_q[3];
                        conv_channel_d = cmd_q[2:0];
                        dout_oe_d      = 1'b1;
                        state_d        = NULL;
                    end
                end
                NULL: begin
                    if (sclk_fall) begin
                        dout_d   = 1'b0;
                        bitcnt_d = DATA_MSB;
                        state_d  = DATA;
                    end
                end
                DATA: begin
                    if (sclk_fall) begin
                        dout_d = result_q[bitcnt_q];
                        if (bitcnt_q == '0) begin
                            state_d = TRAIL;
                        end else begin
                            bitcnt_d = bitcnt_q - 1'b1;
                        end
                    end
                end
                TRAIL: begin
                    if (sclk_fall) dout_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            bitcnt_q       <= '0;
            cmd_q          <= '0;
            result_q       <= '0;
            dout_q         <= 1'b0;
            dout_oe_q      <= 1'b0;
            conv_valid_q   <= 1'b0;
            conv_sgl_q     <= 1'b0;
            conv_channel_q <= '0;
            frame_err_q    <= 1'b0;
            armed_q        <= 1'b0;
            seen_r_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            bitcnt_q       <= bitcnt_d;
            cmd_q          <= cmd_d;
            result_q       <= result_d;
            dout_q         <= dout_d;
            dout_oe_q      <= dout_oe_d;
            conv_valid_q   <= conv_valid_d;
            conv_sgl_q     <= conv_sgl_d;
            conv_channel_q <= conv_channel_d;
            frame_err_q    <= frame_err_d;
            armed_q        <= armed_d;
            seen_r_q       <= seen_r_d;
        end
    end

    assign dout         = dout_q;
    assign dout_oe      = dout_oe_q;
    assign conv_valid   = conv_valid_q;
    assign conv_sgl     = conv_sgl_q;
    assign conv_channel = conv_channel_q;
    assign frame_err    = frame_err_q;

endmodule
